// File: rtl/data_mover_sts_monitor.sv
// -----------------------------------------------------------------------------
// data_mover_sts_monitor
//
// Consumes the AXI DataMover MM2S and S2MM status streams. For each channel it
// tracks in-flight commands, hands out command tags, checks that returned
// status tags arrive in issue order, produces a one-cycle completion pulse for
// every status that retires a command, and keeps sticky error flags.
//
// Optional feature macro: DM_STS_TIMEOUT_EN
//   defined   : per-channel watchdog raises the timeout flag after
//               TIMEOUT_CYCLES cycles with commands outstanding and no status
//   undefined : no watchdog; timeout flags read 0
//
// Ports (top):
//   clk, rst_n                     clock, asynchronous active-low reset
//   mm2s_cmd_issue/s2mm_cmd_issue  one pulse per accepted command
//   mm2s_next_tag/s2mm_next_tag    tag for the next command on each channel
//   mm2s_can_issue/s2mm_can_issue  channel has room for another command
//   s_axis_*_sts_tdata/tvalid/tready
//                                  status streams {OKAY,SLVERR,DECERR,INTERR,TAG[3:0]}
//   mm2s_rd_xfer_cmplt             pulse per MM2S status that retires a command
//   s2mm_wr_xfer_cmplt             pulse per S2MM status that retires a command
//   mm2s_outstanding/s2mm_outstanding
//                                  in-flight command counts
//   clr_err                        synchronous clear of err_flags
//   err_flags                      sticky errors, [6:0] MM2S, [14:8] S2MM:
//                                  {timeout,overflow,spurious,tag_mis,interr,decerr,slverr}
// -----------------------------------------------------------------------------

// One status channel: outstanding counter, tag tracking, error detection.
module data_mover_sts_channel #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = 4,
    parameter int TIMEOUT_CYCLES  = 65535
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_issue,
    input  logic             i_ready,
    input  logic [7:0]       i_sts_tdata,
    input  logic             i_sts_tvalid,
    input  logic             i_clr_err,
    output logic [3:0]       o_next_tag,
    output logic             o_can_issue,
    output logic             o_cmplt,
    output logic [CNT_W-1:0] o_outstanding,
    output logic [6:0]       o_err
);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_next_tag;
    logic [3:0]       r_exp_tag;
    logic             r_cmplt;
    logic [6:0]       r_err;

    logic       w_beat;
    logic       w_match;
    logic       w_cnt_zero;
    logic       w_full;
    logic       w_timeout;
    logic       w_okay;
    logic       w_slverr;
    logic       w_decerr;
    logic       w_interr;
    logic [3:0] w_tag;
    logic [6:0] w_err_set;

    assign {w_okay, w_slverr, w_decerr, w_interr, w_tag} = i_sts_tdata;

    assign w_beat     = i_sts_tvalid & i_ready;
    assign w_cnt_zero = (r_cnt == '0);
    assign w_full     = (r_cnt == MAX_CNT);
    // Only a beat that finds a command in flight retires it.
    assign w_match    = w_beat & ~w_cnt_zero;

    // An issue that coincides with a retiring beat leaves the count unchanged,
    // so it cannot overflow even when the channel is full.
    assign w_err_set = {
        w_timeout,
        i_issue & ~w_match & w_full,
        w_beat & w_cnt_zero,
        w_beat & (w_tag != r_exp_tag),
        w_beat & w_interr,
        w_beat & w_decerr,
        w_beat & (w_slverr | ~(w_okay | w_interr | w_decerr))
    };

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_next_tag <= '0;
            r_exp_tag  <= '0;
            r_cmplt    <= 1'b0;
            r_err      <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values of the others, independent of statement order.
            if (i_issue) begin
                r_next_tag <= r_next_tag + 4'd1;
            end
            if (w_match) begin
                r_exp_tag <= r_exp_tag + 4'd1;
            end
            if (i_issue && !w_match && !w_full) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else if (w_match && !i_issue) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            r_cmplt <= w_match;
            // NOTE: set-dominant -- a new error in the clearing cycle survives.
            r_err   <= (i_clr_err ? 7'd0 : r_err) | w_err_set;
        end
    end

`ifdef DM_STS_TIMEOUT_EN
    localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] r_wd;

    // Fires only on the step into WD_MAX; the counter then parks there,
    // so the flag is raised once per stall.
    assign w_timeout = ~w_beat & ~w_cnt_zero & (r_wd == WD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd <= '0;
        end else if (w_beat || w_cnt_zero) begin
            r_wd <= '0;
        end else if (r_wd != WD_MAX) begin
            r_wd <= r_wd + WD_W'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    assign o_next_tag    = r_next_tag;
    assign o_can_issue   = (r_cnt < MAX_CNT);
    assign o_cmplt       = r_cmplt;
    assign o_outstanding = r_cnt;
    assign o_err         = r_err;
endmodule

module data_mover_sts_monitor #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = 4,
    parameter int TIMEOUT_CYCLES  = 65535
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mm2s_cmd_issue,
    input  logic             s2mm_cmd_issue,
    output logic [3:0]       mm2s_next_tag,
    output logic [3:0]       s2mm_next_tag,
    output logic             mm2s_can_issue,
    output logic             s2mm_can_issue,
    input  logic [7:0]       s_axis_mm2s_sts_tdata,
    input  logic             s_axis_mm2s_sts_tvalid,
    output logic             s_axis_mm2s_sts_tready,
    input  logic [7:0]       s_axis_s2mm_sts_tdata,
    input  logic             s_axis_s2mm_sts_tvalid,
    output logic             s_axis_s2mm_sts_tready,
    output logic             mm2s_rd_xfer_cmplt,
    output logic             s2mm_wr_xfer_cmplt,
    output logic [CNT_W-1:0] mm2s_outstanding,
    output logic [CNT_W-1:0] s2mm_outstanding,
    input  logic             clr_err,
    output logic [15:0]      err_flags
);
    // Ready is low while in reset and high on every cycle afterwards.
    logic       r_ready;
    logic [6:0] w_mm2s_err;
    logic [6:0] w_s2mm_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready <= 1'b0;
        end else begin
            r_ready <= 1'b1;
        end
    end

    data_mover_sts_channel #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .CNT_W           (CNT_W),
        .TIMEOUT_CYCLES  (TIMEOUT_CYCLES)
    ) u_mm2s (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_issue       (mm2s_cmd_issue),
        .i_ready       (r_ready),
        .i_sts_tdata   (s_axis_mm2s_sts_tdata),
        .i_sts_tvalid  (s_axis_mm2s_sts_tvalid),
        .i_clr_err     (clr_err),
        .o_next_tag    (mm2s_next_tag),
        .o_can_issue   (mm2s_can_issue),
        .o_cmplt       (mm2s_rd_xfer_cmplt),
        .o_outstanding (mm2s_outstanding),
        .o_err         (w_mm2s_err)
    );

    data_mover_sts_channel #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .CNT_W           (CNT_W),
        .TIMEOUT_CYCLES  (TIMEOUT_CYCLES)
    ) u_s2mm (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_issue       (s2mm_cmd_issue),
        .i_ready       (r_ready),
        .i_sts_tdata   (s_axis_s2mm_sts_tdata),
        .i_sts_tvalid  (s_axis_s2mm_sts_tvalid),
        .i_clr_err     (clr_err),
        .o_next_tag    (s2mm_next_tag),
        .o_can_issue   (s2mm_can_issue),
        .o_cmplt       (s2mm_wr_xfer_cmplt),
        .o_outstanding (s2mm_outstanding),
        .o_err         (w_s2mm_err)
    );

    assign s_axis_mm2s_sts_tready = r_ready;
    assign s_axis_s2mm_sts_tready = r_ready;
    assign err_flags = {1'b0, w_s2mm_err, 1'b0, w_mm2s_err};
endmodule
